// File: rtl/filter_scheduler.sv
// ============================================================================
// Module : filter_scheduler
// Brief  : Frame-synchronous filter selector with blanked switch-over frames
//          and a per-frame animation phase for the wave filter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module filter_scheduler #(
    parameter int NUM_FILTERS  = 4,
    parameter int AUTO_FRAMES  = 60,
    parameter int BLANK_FRAMES = 2,
    parameter int PHASE_STEP   = 2,
    parameter int V_MAX        = 320
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           next_in,
    input  logic                           auto_en_in,
    input  logic [10:0]                    hcount_in,
    input  logic [9:0]                     vcount_in,
    input  logic                           data_valid_in,
    output logic [$clog2(NUM_FILTERS)-1:0] filter_sel_out,
    output logic [8:0]                     phase_out,
    output logic                           blank_out,
    output logic                           frame_start_out,
    output logic                           busy_out
);

    localparam int SEL_W = $clog2(NUM_FILTERS);
    localparam int FC_W  = (AUTO_FRAMES  > 1) ? $clog2(AUTO_FRAMES)  : 1;
    localparam int BC_W  = (BLANK_FRAMES > 1) ? $clog2(BLANK_FRAMES) : 1;

    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_FILTERS - 1);
    localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(AUTO_FRAMES - 1);
    localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(BLANK_FRAMES - 1);
    localparam logic [9:0]       STEP     = 10'(PHASE_STEP);
    localparam logic [9:0]       VMAX     = 10'(V_MAX);

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        BLANK = 1'b1
    } state_t;

    state_t           state;
    logic             fs_prev;
    logic             pending;
    logic [FC_W-1:0]  frame_cnt;
    logic [BC_W-1:0]  blank_cnt;

    logic             fs_raw;
    logic             fs;
    logic             auto_req;
    logic             go_blank;
    logic             go_run;
    logic             pending_nxt;
    logic [9:0]       phase_sum;
    logic [8:0]       phase_inc;

    // A frame start is the first valid (0,0) sample; repeats of it are ignored.
    assign fs_raw   = data_valid_in && (hcount_in == 11'd0) && (vcount_in == 10'd0);
    assign fs       = fs_raw && !fs_prev;
    assign auto_req = fs && auto_en_in && (frame_cnt == FC_LAST);
    assign go_blank = fs && (state == RUN) && pending;
    assign go_run   = fs && (state == BLANK) && (blank_cnt == BC_LAST);

    // A request landing on the servicing edge survives for the next switch.
    assign pending_nxt = (pending && !go_blank) || next_in || auto_req;

    assign phase_sum = {1'b0, phase_out} + STEP;
    assign phase_inc = 9'((phase_sum >= VMAX) ? (phase_sum - VMAX) : phase_sum);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state           <= RUN;
            fs_prev         <= 1'b0;
            pending         <= 1'b0;
            frame_cnt       <= '0;
            blank_cnt       <= '0;
            filter_sel_out  <= '0;
            phase_out       <= '0;
            blank_out       <= 1'b0;
            frame_start_out <= 1'b0;
            busy_out        <= 1'b0;
        end else begin
            fs_prev         <= fs_raw;
            frame_start_out <= fs;
            pending         <= pending_nxt;
            busy_out        <= go_blank || ((state == BLANK) && !go_run) || pending_nxt;
            if (fs) begin
                case (state)
                    RUN: begin
                        if (pending) begin
                            state     <= BLANK;
                            blank_cnt <= '0;
                            frame_cnt <= '0;
                            blank_out <= 1'b1;
                        end else begin
                            phase_out <= phase_inc;
                            if (auto_en_in) begin
                                frame_cnt <= (frame_cnt == FC_LAST) ? '0 : frame_cnt + 1'b1;
                            end
                        end
                    end
                    BLANK: begin
                        if (blank_cnt == BC_LAST) begin
                            state          <= RUN;
                            filter_sel_out <= (filter_sel_out == SEL_LAST) ? '0
                                                                           : filter_sel_out + 1'b1;
                            phase_out      <= '0;
                            blank_out      <= 1'b0;
                        end else begin
                            blank_cnt <= blank_cnt + 1'b1;
                        end
                    end
                    default: state <= RUN;
                endcase
            end
        end
    end

endmodule

`default_nettype wire
